// File: rtl/oacc_border.sv
// rtl/oacc_border.sv - output-border collector: unary window count -> signed saturating accumulator
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   clr       synchronous clear (accumulator, counters, FSM -> IDLE)
//   en        advance enable for the counting window
//   i_start   window start pulse; samples i_sign / i_accum
//   i_sign    stream sign (1 = negative)
//   i_accum   1 = add window value to accumulator, 0 = replace it
//   i_bit     unary temporal data bit
//   o_valid   result available (DONE)
//   i_ready   downstream accepts result
//   o_data    signed accumulator value
//   o_busy    window counting in progress
module oacc_border #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 i_start,
    input  logic                 i_sign,
    input  logic                 i_accum,
    input  logic                 i_bit,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [ACC_WIDTH-1:0] o_data,
    output logic                 o_busy
);

    localparam logic [WIDTH-1:0]     WIN_W   = WIDTH'(1) << (WIDTH - 1);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     cyc_q, cyc_d;
    logic [WIDTH-1:0]     ones_q, ones_d;
    logic                 sign_q, sign_d;
    logic                 accum_q, accum_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;

    logic [WIDTH-1:0]     cyc_inc;
    logic [ACC_WIDTH-1:0] mag;
    logic [ACC_WIDTH-1:0] value;
    logic [ACC_WIDTH:0]   sum_ext;
    logic [ACC_WIDTH-1:0] sat_sum;

    assign cyc_inc = cyc_q + WIDTH'(1);

    // Magnitude never exceeds WIN, so it fits as a positive ACC_WIDTH value
    // and its negation cannot overflow; -0 naturally yields 0.
    assign mag   = {{(ACC_WIDTH-WIDTH){1'b0}}, ones_q};
    assign value = sign_q ? (~mag + ACC_WIDTH'(1)) : mag;

    // One guard bit: overflow shows up as disagreement of the top two bits.
    assign sum_ext = {acc_q[ACC_WIDTH-1], acc_q} + {value[ACC_WIDTH-1], value};
    always_comb begin
        sat_sum = sum_ext[ACC_WIDTH-1:0];
        if (sum_ext[ACC_WIDTH] != sum_ext[ACC_WIDTH-1]) begin
            sat_sum = sum_ext[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            ones_q  <= '0;
            sign_q  <= 1'b0;
            accum_q <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            ones_q  <= ones_d;
            sign_q  <= sign_d;
            accum_q <= accum_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        ones_d  = ones_q;
        sign_d  = sign_q;
        accum_d = accum_q;
        acc_d   = acc_q;
        if (clr) begin
            state_d = S_IDLE;
            cyc_d   = '0;
            ones_d  = '0;
            sign_d  = 1'b0;
            accum_d = 1'b0;
            acc_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_d = S_COUNT;
                        sign_d  = i_sign;
                        accum_d = i_accum;
                        cyc_d   = '0;
                        ones_d  = '0;
                    end
                end
                S_COUNT: begin
                    if (en) begin
                        cyc_d  = cyc_inc;
                        ones_d = ones_q + {{(WIDTH-1){1'b0}}, i_bit};
                        if (cyc_inc == WIN_W) begin
                            state_d = S_UPDATE;
                        end
                    end
                end
                S_UPDATE: begin
                    acc_d   = accum_q ? sat_sum : value;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    if (i_ready) begin
                        if (i_start) begin
                            // back-to-back window: handshake and restart together
                            state_d = S_COUNT;
                            sign_d  = i_sign;
                            accum_d = i_accum;
                            cyc_d   = '0;
                            ones_d  = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign o_valid = (state_q == S_DONE);
    assign o_busy  = (state_q == S_COUNT);
    assign o_data  = acc_q;

endmodule

// File: tb/tb_oacc_border.sv
// tb/tb_oacc_border.sv - directed self-checking bench for oacc_border (ACC_WIDTH 16 and 9 in lockstep)
module tb_oacc_border;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr = 1'b0;
    logic en = 1'b0;
    logic i_start = 1'b0;
    logic i_sign = 1'b0;
    logic i_accum = 1'b0;
    logic i_bit = 1'b0;
    logic i_ready = 1'b0;

    logic        valid16, busy16, valid9, busy9;
    logic [15:0] data16;
    logic [8:0]  data9;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    oacc_border #(.WIDTH(8), .ACC_WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .i_start(i_start),
        .i_sign(i_sign), .i_accum(i_accum), .i_bit(i_bit),
        .o_valid(valid16), .i_ready(i_ready), .o_data(data16), .o_busy(busy16)
    );

    oacc_border #(.WIDTH(8), .ACC_WIDTH(9)) dut9 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .i_start(i_start),
        .i_sign(i_sign), .i_accum(i_accum), .i_bit(i_bit),
        .o_valid(valid9), .i_ready(i_ready), .o_data(data9), .o_busy(busy9)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int d16();
        return int'($signed(data16));
    endfunction

    function automatic int d9();
        return int'($signed(data9));
    endfunction

    task automatic start_win(input logic sign, input logic accum, input logic rdy);
        i_start = 1'b1;
        i_sign  = sign;
        i_accum = accum;
        i_ready = rdy;
        tick();
        i_start = 1'b0;
        i_ready = 1'b0;
        chk("start_busy", int'(busy16 & busy9), 1);
        chk("start_valid", int'(valid16 | valid9), 0);
    endtask

    // 128 counted cycles, ones on the first n; optional en=0 cycle (with i_bit=1,
    // which must be ignored) before every counted cycle.
    task automatic count_win(input int ones, input bit toggle);
        int bad = 0;
        int el  = 0;
        for (int k = 0; k < 128; k++) begin
            if (toggle) begin
                en = 1'b0;
                i_bit = 1'b1;
                tick();
                el++;
                if (!(busy16 && busy9)) bad++;
            end
            en = 1'b1;
            i_bit = (k < ones);
            tick();
            el++;
            if (k < 127 && !(busy16 && busy9)) bad++;
        end
        en = 1'b0;
        i_bit = 1'b0;
        chk("busy_in_count", bad, 0);
        if (toggle) chk("elapsed", el, 256);
        chk("update_valid", int'(valid16 | valid9), 0);
        chk("update_busy", int'(busy16 | busy9), 0);
        tick();
        chk("done_valid", int'(valid16 & valid9), 1);
    endtask

    task automatic res(input string tag, input int e16, input int e9);
        chk({tag, "_d16"}, d16(), e16);
        chk({tag, "_d9"}, d9(), e9);
    endtask

    task automatic accept();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("accept_valid", int'(valid16 | valid9), 0);
        chk("accept_busy", int'(busy16 | busy9), 0);
    endtask

    initial begin
        int vcnt;
        // reset
        #1 rst = 1'b1;
        #2;
        chk("rst_valid", int'(valid16 | valid9), 0);
        chk("rst_busy", int'(busy16 | busy9), 0);
        res("rst", 0, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("idle_busy", int'(busy16 | busy9), 0);

        // replace with +37, then hold with ready low while start pulses
        start_win(1'b0, 1'b0, 1'b0);
        count_win(37, 1'b0);
        res("w37", 37, 37);
        for (int c = 0; c < 5; c++) begin
            i_start = (c % 2 == 0);
            tick();
            chk("hold_valid", int'(valid16 & valid9), 1);
            chk("hold_busy", int'(busy16 | busy9), 0);
            res("hold", 37, 37);
        end
        i_start = 1'b0;

        // back-to-back start with handshake
        start_win(1'b1, 1'b1, 1'b1);
        count_win(100, 1'b0);
        res("w_m63", -63, -63);
        accept();

        start_win(1'b1, 1'b1, 1'b0);
        count_win(128, 1'b0);
        res("w_m191", -191, -191);
        accept();

        // en toggling 50%
        start_win(1'b0, 1'b0, 1'b0);
        count_win(20, 1'b1);
        res("w20", 20, 20);
        accept();

        // clear, then positive saturation
        clr = 1'b1;
        tick();
        clr = 1'b0;
        res("clr0", 0, 0);
        start_win(1'b0, 1'b1, 1'b0); count_win(128, 1'b0); res("pos1", 128, 128); accept();
        start_win(1'b0, 1'b1, 1'b0); count_win(128, 1'b0); res("pos2", 256, 255); accept();
        start_win(1'b0, 1'b1, 1'b0); count_win(128, 1'b0); res("pos3", 384, 255); accept();

        // negative saturation
        start_win(1'b1, 1'b0, 1'b0); count_win(128, 1'b0); res("neg1", -128, -128); accept();
        start_win(1'b1, 1'b1, 1'b0); count_win(128, 1'b0); res("neg2", -256, -256); accept();
        start_win(1'b1, 1'b1, 1'b0); count_win(128, 1'b0); res("neg3", -384, -256); accept();

        // clr mid-window with a simultaneous start
        start_win(1'b0, 1'b0, 1'b0);
        count_win(37, 1'b0);
        res("pre_clr", 37, 37);
        accept();
        start_win(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 60; k++) begin
            en = 1'b1;
            i_bit = k[0];
            tick();
        end
        clr = 1'b1;
        i_start = 1'b1;
        tick();
        clr = 1'b0;
        i_start = 1'b0;
        chk("clr_busy", int'(busy16 | busy9), 0);
        chk("clr_valid", int'(valid16 | valid9), 0);
        res("clr", 0, 0);
        vcnt = 0;
        for (int k = 0; k < 140; k++) begin
            en = 1'b1;
            i_bit = 1'b1;
            tick();
            if (valid16 || valid9 || busy16 || busy9) vcnt++;
        end
        en = 1'b0;
        i_bit = 1'b0;
        chk("post_clr_quiet", vcnt, 0);

        // async reset mid-count
        start_win(1'b0, 1'b0, 1'b0);
        count_win(5, 1'b0);
        res("w5", 5, 5);
        accept();
        start_win(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 30; k++) begin
            en = 1'b1;
            i_bit = 1'b1;
            tick();
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", int'(busy16 | busy9), 0);
        chk("arst_valid", int'(valid16 | valid9), 0);
        res("arst", 0, 0);
        tick();
        rst = 1'b0;
        en = 1'b0;
        i_bit = 1'b0;
        tick();
        chk("arst_idle_busy", int'(busy16 | busy9), 0);
        res("arst_idle", 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
